button_bounce_gen: RTL and testbench



---
 rtl/button_stim_pkg.sv | 29 ++
 rtl/lfsr16.sv | 29 ++
 rtl/button_bounce_gen.sv | 139 +++++++++++++
 tb/tb_button_bounce_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/button_stim_pkg.sv
// Shared types and constants for the mechanical-switch emulator (button_bounce_gen).
// The optional LFSR is described here but only built when BOUNCE_RAND_EN is defined.
package button_stim_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_BOUNCE,
      HOLD,
      RELEASE_BOUNCE
   } state_e;

   localparam int LFSR_W = 16;
   // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
   localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

   localparam int PULSE_W = 4;

   function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
   endfunction

   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR shifting left; used by button_bounce_gen only when BOUNCE_RAND_EN is defined.
// A zero seed would lock the register up, so it is swapped for the default seed.
module lfsr16
   import button_stim_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] q
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsrNext(lfsr_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= (seed == '0) ? LFSR_DEFAULT_SEED : seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/button_bounce_gen.sv
// Mechanical-switch emulator: press bounce, steady hold, release bounce, then a done pulse.
// Define BOUNCE_RAND_EN to draw pulse count and half-period lengths from an LFSR.
module button_bounce_gen
   import button_stim_pkg::*;
#(
   parameter int          BOUNCE_PULSES = 2,
   parameter int          BOUNCE_GAP    = 3,
   parameter int          HOLD_CYCLES   = 10,
   parameter logic [7:0]  GAP_MASK      = 8'h0F,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
)(
   input  logic clk,
   input  logic reset,
   input  logic press_req,
   output logic ready,
   output logic Button,
   output logic done
);

   localparam int SEG_MAX = maxOf3(BOUNCE_GAP, int'(GAP_MASK) + 1, HOLD_CYCLES);
   localparam int SEG_W   = $clog2(SEG_MAX + 1);
   localparam logic [SEG_W-1:0]   HOLD_LAST = SEG_W'(HOLD_CYCLES - 1);
   localparam logic [PULSE_W-1:0] PULSE_CAP = PULSE_W'(BOUNCE_PULSES);
   localparam logic [PULSE_W-1:0] PULSE_ONE = PULSE_W'(1);

   state_e             state_q;
   logic [SEG_W-1:0]   seg_q;
   logic [PULSE_W-1:0] pulse_q;
   logic [PULSE_W-1:0] k_q;
   logic               button_q;
   logic               done_q;

   logic [PULSE_W-1:0] kNew;
   logic [SEG_W-1:0]   gapLast;

`ifdef BOUNCE_RAND_EN
   logic [LFSR_W-1:0] lfsr;

   lfsr16 uLfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .q     (lfsr)
   );

   assign kNew    = (lfsr[3:0] < PULSE_CAP) ? lfsr[3:0] : PULSE_CAP;
   assign gapLast = SEG_W'(lfsr[7:0] & GAP_MASK);
`else
   assign kNew    = PULSE_CAP;
   assign gapLast = SEG_W'(BOUNCE_GAP - 1);
`endif

   // seg_q holds the cycles left in the current segment after this one,
   // pulse_q the bounce pulses left including the one in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         seg_q    <= '0;
         pulse_q  <= '0;
         k_q      <= '0;
         button_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               button_q <= 1'b0;
               if (press_req) begin
                  k_q      <= kNew;
                  pulse_q  <= kNew;
                  button_q <= 1'b1;
                  if (kNew == '0) begin
                     state_q <= HOLD;
                     seg_q   <= HOLD_LAST;
                  end else begin
                     state_q <= PRESS_BOUNCE;
                     seg_q   <= gapLast;
                  end
               end
            end
            PRESS_BOUNCE: begin
               if (seg_q != '0) begin
                  seg_q <= seg_q - 1'b1;
               end else if (button_q) begin
                  button_q <= 1'b0;
                  seg_q    <= gapLast;
               end else if (pulse_q == PULSE_ONE) begin
                  state_q  <= HOLD;
                  button_q <= 1'b1;
                  seg_q    <= HOLD_LAST;
               end else begin
                  pulse_q  <= pulse_q - 1'b1;
                  button_q <= 1'b1;
                  seg_q    <= gapLast;
               end
            end
            HOLD: begin
               if (seg_q != '0) begin
                  seg_q <= seg_q - 1'b1;
               end else if (k_q == '0) begin
                  state_q  <= IDLE;
                  button_q <= 1'b0;
                  done_q   <= 1'b1;
               end else begin
                  state_q  <= RELEASE_BOUNCE;
                  button_q <= 1'b0;
                  seg_q    <= gapLast;
                  pulse_q  <= k_q;
               end
            end
            RELEASE_BOUNCE: begin
               if (seg_q != '0) begin
                  seg_q <= seg_q - 1'b1;
               end else if (!button_q) begin
                  button_q <= 1'b1;
                  seg_q    <= gapLast;
               end else if (pulse_q == PULSE_ONE) begin
                  state_q  <= IDLE;
                  button_q <= 1'b0;
                  done_q   <= 1'b1;
               end else begin
                  pulse_q  <= pulse_q - 1'b1;
                  button_q <= 1'b0;
                  seg_q    <= gapLast;
               end
            end
            default: begin
               state_q  <= IDLE;
               button_q <= 1'b0;
            end
         endcase
      end
   end

   assign ready  = (state_q == IDLE);
   assign Button = button_q;
   assign done   = done_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen: a default instance and a zero-bounce instance checked
// against a waveform model built from half-period lengths (LFSR-driven under BOUNCE_RAND_EN).
module tb_button_bounce_gen;

   localparam int          BP   = 2;
   localparam int          BG   = 3;
   localparam int          HC   = 10;
   localparam logic [7:0]  GM   = 8'h0F;
   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk;
   logic [1:0] rst;
   logic [1:0] req;
   logic [1:0] btn;
   logic [1:0] rdy;
   logic [1:0] dn;

   int          checkCount = 0;
   int          errorCount = 0;
   int unsigned cyc;
   bit          active [2];
   int unsigned t0 [2];
   int          kM [2];
   int          glen [2][64];
   logic [15:0] lf [2];
   int          pcap [2] = '{BP, 0};
   int unsigned doneLog [$];

   button_bounce_gen #(
      .BOUNCE_PULSES (BP),
      .BOUNCE_GAP    (BG),
      .HOLD_CYCLES   (HC),
      .GAP_MASK      (GM),
      .LFSR_SEED     (SEED)
   ) dutMain (
      .clk       (clk),
      .reset     (rst[0]),
      .press_req (req[0]),
      .ready     (rdy[0]),
      .Button    (btn[0]),
      .done      (dn[0])
   );

   button_bounce_gen #(
      .BOUNCE_PULSES (0),
      .BOUNCE_GAP    (BG),
      .HOLD_CYCLES   (HC),
      .GAP_MASK      (GM),
      .LFSR_SEED     (SEED)
   ) dutNoBounce (
      .clk       (clk),
      .reset     (rst[1]),
      .press_req (req[1]),
      .ready     (rdy[1]),
      .Button    (btn[1]),
      .done      (dn[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, actual, expected);
      end
   endtask

   function automatic logic [15:0] lfStep(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // Plan a whole sequence at acceptance: pulse count and every half-period length.
   task automatic startSeq(input int idx);
      logic [15:0] lc;
      int g;
      lc = lf[idx];
      active[idx] = 1'b1;
      t0[idx] = cyc;
`ifdef BOUNCE_RAND_EN
      kM[idx] = (int'(lc[3:0]) < pcap[idx]) ? int'(lc[3:0]) : pcap[idx];
`else
      kM[idx] = pcap[idx];
`endif
      for (int i = 0; i < 4 * kM[idx]; i++) begin
         if (i == 2 * kM[idx]) begin
            for (int h = 0; h < HC; h++) lc = lfStep(lc);
         end
`ifdef BOUNCE_RAND_EN
         g = 1 + int'(lc[7:0] & GM);
`else
         g = BG;
`endif
         glen[idx][i] = g;
         for (int s = 0; s < g; s++) lc = lfStep(lc);
      end
   endtask

   task automatic expOut(input int idx, output logic eb, output logic ed, output logic er);
      int off;
      int pos;
      eb = 1'b0;
      ed = 1'b0;
      er = 1'b1;
      if (!active[idx]) return;
      er  = 1'b0;
      off = int'(cyc - t0[idx]);
      pos = 1;
      for (int i = 0; i < 2 * kM[idx]; i++) begin
         if (off < pos + glen[idx][i]) begin
            eb = (i % 2 == 0);
            return;
         end
         pos += glen[idx][i];
      end
      if (off < pos + HC) begin
         eb = 1'b1;
         return;
      end
      pos += HC;
      for (int i = 2 * kM[idx]; i < 4 * kM[idx]; i++) begin
         if (off < pos + glen[idx][i]) begin
            eb = (i % 2 == 1);
            return;
         end
         pos += glen[idx][i];
      end
      ed = 1'b1;
      er = 1'b1;
   endtask

   // One cycle: compare outputs at the falling edge, then drive inputs for the next rising edge.
   task automatic applyStimulus(input logic [1:0] pr, input logic [1:0] rs);
      logic eb, ed, er;
      for (int d = 0; d < 2; d++) begin
         expOut(d, eb, ed, er);
         checkOutput($sformatf("dut%0d Button", d), 32'(btn[d]), 32'(eb));
         checkOutput($sformatf("dut%0d done", d), 32'(dn[d]), 32'(ed));
         checkOutput($sformatf("dut%0d ready", d), 32'(rdy[d]), 32'(er));
         if (d == 0 && ed) doneLog.push_back(cyc);
         if (ed) active[d] = 1'b0;
         if (rs[d]) active[d] = 1'b0;
         else if (pr[d] && er) startSeq(d);
      end
      req = pr;
      rst = rs;
      @(posedge clk);
      for (int d = 0; d < 2; d++) lf[d] = rs[d] ? SEED : lfStep(lf[d]);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] rp;
      logic [1:0] rr;
      req = 2'b00;
      rst = 2'b11;
      cyc = 0;
      repeat (2) @(posedge clk);
      lf[0] = SEED;
      lf[1] = SEED;
      active[0] = 1'b0;
      active[1] = 1'b0;
      @(negedge clk);

      applyStimulus(2'b00, 2'b00);

      // Single press, then idle long enough for the full sequence
      applyStimulus(2'b11, 2'b00);
      repeat (40) applyStimulus(2'b00, 2'b00);

      // Requests while busy must be dropped
      for (int i = 0; i < 45; i++)
         applyStimulus((i == 0 || i == 5 || i == 20) ? 2'b11 : 2'b00, 2'b00);

      // Reset in the middle of hold, then a fresh press
      for (int i = 0; i < 60; i++)
         applyStimulus((i == 0 || i == 17) ? 2'b11 : 2'b00, (i == 15) ? 2'b11 : 2'b00);

      // Request held high: sequences run back to back
      doneLog.delete();
      repeat (110) applyStimulus(2'b11, 2'b00);
`ifndef BOUNCE_RAND_EN
      checkOutput("done count", 32'(doneLog.size() >= 2), 32'd1);
      for (int i = 1; i < doneLog.size(); i++)
         checkOutput("done period", doneLog[i] - doneLog[i-1], 32'(4 * BP * BG + HC + 1));
`endif
      repeat (40) applyStimulus(2'b00, 2'b00);

      // Random requests with occasional resets
      repeat (800) begin
         rp = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
         rr = {1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 199) == 0)};
         applyStimulus(rp, rr);
      end
      repeat (80) applyStimulus(2'b00, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
